// File: rtl/regfile_wb_queue.sv
// Writeback queue in front of the 3-port register file: buffers writes in order,
// drains one per cycle onto we3/wa3/wd3, and forwards pending data to two read ports.
module regfile_wb_queue #(
  parameter int n     = 16,
  parameter int r     = 3,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [r-1:0]             in_addr,
  input  logic [n-1:0]             in_data,
  input  logic                     drain_en,
  output logic                     we3,
  output logic [r-1:0]             wa3,
  output logic [n-1:0]             wd3,
  input  logic [r-1:0]             fra1,
  input  logic [r-1:0]             fra2,
  output logic                     fhit1,
  output logic                     fhit2,
  output logic [n-1:0]             fd1,
  output logic [n-1:0]             fd2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [r-1:0]  addr_mem [DEPTH];
  logic [n-1:0]  data_mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] cnt;
  logic          nonempty;
  logic          push;
  logic          pop;

  assign nonempty = (cnt != '0);
  assign in_ready = rst_n && (cnt < CW'(DEPTH));
  // Register-0 writes complete the handshake but are dropped here.
  assign push     = in_valid && in_ready && (in_addr != '0);
  assign we3      = nonempty && drain_en;
  assign pop      = we3;
  assign wa3      = nonempty ? addr_mem[head] : '0;
  assign wd3      = nonempty ? data_mem[head] : '0;
  assign count    = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail] <= in_addr;
      data_mem[tail] <= in_data;
    end
  end

  // Walk from head toward tail so the newest matching entry overrides older ones.
  function automatic logic [n:0] lookup(input logic [r-1:0] fa);
    logic          hit;
    logic [n-1:0]  d;
    logic [PW-1:0] idx;
    hit = 1'b0;
    d   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if ((CW'(i) < cnt) && (fa != '0) && (addr_mem[idx] == fa)) begin
        hit = 1'b1;
        d   = data_mem[idx];
      end
    end
    return {hit, d};
  endfunction

  always_comb begin
    {fhit1, fd1} = lookup(fra1);
    {fhit2, fd2} = lookup(fra2);
  end

endmodule
